// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared pixel type, swap FSM states, default VGA timing and a sizing helper
// for the double-buffered framebuffer.
package vga_fb_pkg;
  localparam int CH_W_DEF = 8;
  localparam int H_RES_DEF = 640, V_RES_DEF = 480;
  localparam int H_FP_DEF = 16, H_SYNC_DEF = 96, H_BP_DEF = 48;
  localparam int V_FP_DEF = 10, V_SYNC_DEF = 2, V_BP_DEF = 33;
  typedef struct packed {
    logic [CH_W_DEF-1:0] r, g, b;
  } rgb_t;
  typedef enum logic [1:0] {S_IDLE, S_PEND, S_CLEAR} swap_st_t;
  function automatic int aw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vga_fb_timing.sv
// vga_timing: clock/line counters (two clocks per pixel) with sync, blank, pixel-enable,
// frame_start and vblank-entry strobes.
module vga_timing
  import vga_fb_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF,
  localparam int HT = H_RES + H_FP + H_SYNC + H_BP,
  localparam int VT = V_RES + V_FP + V_SYNC + V_BP,
  localparam int HW = aw(2 * HT),
  localparam int VW = aw(VT)
) (
  input  logic          clk50,
  input  logic          reset_n,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hs,
  output logic          vs,
  output logic          active,
  output logic          pix_en,
  output logic          frame_start,
  output logic          vblank_entry
);
  logic h_last, v_last;
  int px, ln;
  assign px = int'(hcount[HW-1:1]);
  assign ln = int'(vcount);
  assign h_last = hcount == HW'(2 * HT - 1);
  assign v_last = vcount == VW'(VT - 1);
  assign active = px < H_RES && ln < V_RES;
  assign hs = !(px >= H_RES + H_FP && px < H_RES + H_FP + H_SYNC);
  assign vs = !(ln >= V_RES + V_FP && ln < V_RES + V_FP + V_SYNC);
  assign pix_en = hcount[0];
  assign vblank_entry = h_last && ln == V_RES - 1;
  // frame_start is registered so it coincides with the 0,0 counter state but is low out of reset
  always_ff @(posedge clk50 or negedge reset_n)
    if (!reset_n) begin
      hcount <= '0;
      vcount <= '0;
      frame_start <= 1'b0;
    end else begin
      hcount <= h_last ? '0 : hcount + HW'(1);
      vcount <= !h_last ? vcount : v_last ? '0 : vcount + VW'(1);
      frame_start <= h_last && v_last;
    end
endmodule

// File: rtl/vga_fb_dbuf.sv
// vga_fb_dbuf: double-buffered VGA framebuffer with a valid/ready write port and a bank swap
// taken at vblank entry. Define VGA_FB_CLEAR_EN to fill the new back bank with CLEAR_RGB after each swap.
module vga_fb_dbuf
  import vga_fb_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF,
  parameter int CH_W = CH_W_DEF,
  parameter logic [3*CH_W-1:0] CLEAR_RGB = '0,
  localparam int HW = aw(2 * (H_RES + H_FP + H_SYNC + H_BP)),
  localparam int VW = aw(V_RES + V_FP + V_SYNC + V_BP),
  localparam int XW = aw(H_RES + 1),
  localparam int YW = aw(V_RES + 1),
  localparam int DEPTH = H_RES * V_RES,
  localparam int AW = aw(DEPTH)
) (
  input  logic              clk50,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [XW-1:0]     wr_x,
  input  logic [YW-1:0]     wr_y,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic              swap_req,
  output logic              swap_done,
  output logic              front_sel,
  output logic              frame_start,
  output logic [CH_W-1:0]   VGA_R,
  output logic [CH_W-1:0]   VGA_G,
  output logic [CH_W-1:0]   VGA_B,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_n,
  output logic              VGA_SYNC_n
);
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic hs, vs, active, pix_en, vblank_entry, we, clearing, swap_now;
  logic [3*CH_W-1:0] mem [2][DEPTH];
  logic [3*CH_W-1:0] wdata;
  logic [AW-1:0] raddr, waddr, clr_addr;
  swap_st_t st;
  vga_timing #(
    .H_RES(H_RES), .V_RES(V_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk50(clk50), .reset_n(reset_n), .hcount(hcount), .vcount(vcount), .hs(hs), .vs(vs),
    .active(active), .pix_en(pix_en), .frame_start(frame_start), .vblank_entry(vblank_entry)
  );
  assign raddr = AW'(int'(vcount) * H_RES + int'(hcount[HW-1:1]));
  assign clearing = st == S_CLEAR;
  assign wr_ready = !clearing;
  assign swap_now = st == S_PEND && vblank_entry;
  // off-screen writes still handshake but never reach the memory
  assign we = clearing || (wr_valid && int'(wr_x) < H_RES && int'(wr_y) < V_RES);
  assign waddr = clearing ? clr_addr : AW'(int'(wr_y) * H_RES + int'(wr_x));
  assign wdata = clearing ? CLEAR_RGB : wr_rgb;
  assign VGA_CLK = hcount[0];
  assign VGA_SYNC_n = 1'b1;
  always_ff @(posedge clk50)
    if (we) mem[!front_sel][waddr] <= wdata;
  always_ff @(posedge clk50 or negedge reset_n)
    if (!reset_n) begin
      st <= S_IDLE;
      front_sel <= 1'b0;
      swap_done <= 1'b0;
      clr_addr <= '0;
    end else begin
      swap_done <= swap_now;
      clr_addr <= clearing ? clr_addr + AW'(1) : '0;
      if (swap_now) front_sel <= !front_sel;
`ifdef VGA_FB_CLEAR_EN
      st <= st == S_IDLE ? (swap_req ? S_PEND : S_IDLE) :
            st == S_PEND ? (vblank_entry ? S_CLEAR : S_PEND) :
            clr_addr == AW'(DEPTH - 1) ? S_IDLE : S_CLEAR;
`else
      st <= st == S_IDLE ? (swap_req ? S_PEND : S_IDLE) : vblank_entry ? S_IDLE : S_PEND;
`endif
    end
  // DAC outputs load together on odd clocks so they are stable at the VGA_CLK rising edge
  always_ff @(posedge clk50 or negedge reset_n)
    if (!reset_n) begin
      {VGA_R, VGA_G, VGA_B} <= '0;
      VGA_BLANK_n <= 1'b0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else if (pix_en) begin
      {VGA_R, VGA_G, VGA_B} <= active ? mem[front_sel][raddr] : '0;
      VGA_BLANK_n <= active;
      VGA_HS <= hs;
      VGA_VS <= vs;
    end
endmodule

// File: tb/tb_vga_fb_dbuf.sv
// tb_vga_fb_dbuf: self-checking bench for vga_fb_dbuf at 8x4 pixels with 1-wide porches and syncs,
// using a time-indexed reference model plus hand-computed literal expectations.
module tb_vga_fb_dbuf;
  import vga_fb_pkg::*;
  localparam int HR = 8, VR = 4, LT = 22, FT = 154, DEPTH = 32;
`ifdef VGA_FB_CLEAR_EN
  localparam logic [23:0] CLR = 24'hFF0000;
  localparam int CLR_CYC = 32, RST_CNT = 0;
`else
  localparam logic [23:0] CLR = 24'h000000;
  localparam int CLR_CYC = 0, RST_CNT = 2;
`endif
  logic clk50 = 0, reset_n = 1, wr_valid = 0, swap_req = 0;
  logic [3:0] wr_x = 0;
  logic [2:0] wr_y = 0;
  logic [23:0] wr_rgb = 0;
  logic wr_ready, swap_done, front_sel, frame_start;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;
  rgb_t dac;
  int n_chk = 0, n_fail = 0;
  assign dac = {VGA_R, VGA_G, VGA_B};
  always #5 clk50 = ~clk50;

  vga_fb_dbuf #(
    .H_RES(8), .V_RES(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CH_W(8), .CLEAR_RGB(CLR)
  ) dut (
    .clk50(clk50), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x),
    .wr_y(wr_y), .wr_rgb(wr_rgb), .swap_req(swap_req), .swap_done(swap_done),
    .front_sel(front_sel), .frame_start(frame_start), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: t counts clock edges since reset; position in the frame is t mod 154.
  logic [23:0] m_mem [2][DEPTH];
  bit m_known [2][DEPTH];
  int t, clr_left;
  bit m_front, m_pend, e_done, e_fs, e_blank, e_hs, e_vs, e_rgb_k;
  logic [23:0] e_rgb;
  always @(posedge clk50 or negedge reset_n) begin
    int h, v, p, a;
    bit act, clr_pre, swap_now;
    if (!reset_n) begin
      t = 0; m_front = 0; m_pend = 0; clr_left = 0; e_done = 0; e_fs = 0;
      e_rgb = 0; e_rgb_k = 1; e_blank = 0; e_hs = 1; e_vs = 1;
    end else begin
      h = t % LT;
      v = (t % FT) / LT;
      p = h / 2;
      if (h % 2 == 1) begin
        act = p < HR && v < VR;
        a = act ? v * HR + p : 0;
        e_blank = act;
        e_hs = p != HR + 1;
        e_vs = v != VR + 1;
        e_rgb = act ? m_mem[m_front][a] : 24'h0;
        e_rgb_k = !act || m_known[m_front][a];
      end
      clr_pre = clr_left > 0;
      if (clr_pre) begin
        a = DEPTH - clr_left;
        m_mem[!m_front][a] = CLR;
        m_known[!m_front][a] = 1;
        clr_left--;
      end else if (wr_valid && wr_x < HR && wr_y < VR) begin
        a = int'(wr_y) * HR + int'(wr_x);
        m_mem[!m_front][a] = wr_rgb;
        m_known[!m_front][a] = 1;
      end
      swap_now = m_pend && h == LT - 1 && v == VR - 1;
      e_done = swap_now;
      if (swap_now) begin
        m_front = !m_front;
        m_pend = 0;
        clr_left = CLR_CYC;
      end else if (!m_pend && !clr_pre && swap_req) m_pend = 1;
      t++;
      e_fs = (t % FT) == 0;
    end
  end

  always @(negedge clk50) begin
    if (e_rgb_k) chk("dac_rgb", dac, e_rgb);
    chk("dac_ctl", {VGA_BLANK_n, VGA_HS, VGA_VS, VGA_CLK, VGA_SYNC_n},
        {e_blank, e_hs, e_vs, 1'((t % LT) % 2), 1'b1});
    chk("swap_ctl", {swap_done, front_sel, frame_start, wr_ready},
        {e_done, m_front, e_fs, clr_left == 0});
  end

  task automatic wr(input int x, input int y, input logic [23:0] c);
    int n = 0;
    @(negedge clk50);
    while (!wr_ready && n < 100) begin n++; @(negedge clk50); end
    if (n == 100) chk("wr_ready_wait", wr_ready, 1);
    wr_valid = 1; wr_x = 4'(x); wr_y = 3'(y); wr_rgb = c;
    @(negedge clk50);
    wr_valid = 0;
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin @(negedge clk50); n++; end while (!frame_start && n < 400);
    if (!frame_start) chk("frame_start_wait", frame_start, 1);
  endtask

  task automatic swap_pulse();
    int n = 0;
    @(negedge clk50); swap_req = 1;
    @(negedge clk50); swap_req = 0;
    while (!swap_done && n < 400) begin @(negedge clk50); n++; end
    if (!swap_done) chk("swap_done_wait", swap_done, 1);
  endtask

  task automatic scan(input logic [23:0] c, output int first, output int cnt);
    wait_fs();
    first = -1; cnt = 0;
    for (int k = 0; k < FT; k++) begin
      if (dac == c) begin if (first < 0) first = k; cnt++; end
      @(negedge clk50);
    end
  endtask

  initial begin
    int n, k, hs_low, first, cnt, nd, d0, d1, rdy_low;
    #1 reset_n = 0;
    repeat (3) @(negedge clk50);
    chk("rst_hs", VGA_HS, 1);
    chk("rst_vs", VGA_VS, 1);
    chk("rst_blank_n", VGA_BLANK_n, 0);
    chk("rst_front_sel", front_sel, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_swap_done", swap_done, 0);
    @(posedge clk50); #2 reset_n = 1;
    hs_low = 0;
    repeat (LT) begin @(negedge clk50); hs_low += int'(!VGA_HS); end
    chk("hs_low_clocks", hs_low, 2);
    wait_fs();
    n = 0;
    do begin @(negedge clk50); n++; end while (!frame_start && n < 400);
    chk("frame_period", n, FT);
    for (int a = 0; a < DEPTH; a++) wr(a % HR, a / HR, 24'h0);
    swap_pulse();
    for (int a = 0; a < DEPTH; a++) wr(a % HR, a / HR, 24'h0);
    wr(3, 2, 24'h123456);
    wait_fs();
    k = 0;
    while (!swap_done && k < 400) begin
      @(negedge clk50); k++;
      swap_req = k == 27;
    end
    chk("swap_done_clock", k, 88);
    chk("swap_front_sel", front_sel, 0);
    scan(24'h123456, first, cnt);
    chk("pixel_first_clock", first, 52);
    chk("pixel_count", cnt, 2);
    @(negedge clk50);
    chk("oor_wr_ready", wr_ready, 1);
    wr(8, 0, 24'hABCDEF);
    wr(7, 3, 24'h0F0F0F);
    @(negedge clk50); swap_req = 1;
    nd = 0; k = 0; d0 = 0; d1 = 0; rdy_low = 0;
    while (nd < 2 && k < 800) begin
      @(negedge clk50); k++;
      if (swap_done) begin
        nd++;
        if (nd == 1) d0 = k;
        else begin d1 = k; swap_req = 0; end
      end
      if (nd == 1) rdy_low += int'(!wr_ready);
    end
    swap_req = 0;
    chk("b2b_pulses", nd, 2);
    chk("b2b_spacing", d1 - d0, FT);
    chk("clear_ready_low", rdy_low, CLR_CYC);
    wait_fs();
    wait_fs();
    swap_pulse();
    repeat (40) @(posedge clk50);
    #2 reset_n = 0;
    @(negedge clk50);
    chk("midrst_front_sel", front_sel, 0);
    chk("midrst_hs", VGA_HS, 1);
    chk("midrst_blank_n", VGA_BLANK_n, 0);
    @(posedge clk50); #2 reset_n = 1;
    scan(24'h123456, first, cnt);
    chk("midrst_pixel_count", cnt, RST_CNT);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
